semi_auto_ctrl: RTL and testbench

Sequencer for semi-automatic driving mode. It runs the car straight until the detectors report an intersection or a wall, then stops and waits for a single driver command. It executes that command as a timed turn and a timed clearance run before detection resumes. It sits between the debounced button/detector inputs and the motion outputs that feed the car's drive interface.

---
 rtl/semi_auto_ctrl.sv | 168 ++++++++++++++++
 tb/tb_semi_auto_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/semi_auto_ctrl.sv
// semi_auto_ctrl: semi-automatic driving sequencer.
// Runs straight until an intersection or wall, waits for one driver command,
// then performs a timed turn followed by a timed clearance run.
// Optional feature: define SEMI_AUTO_DEADEND_EN to turn around automatically
// at a dead end (front, left and right all blocked).
//
// Handshake note: there is no valid/ready traffic here. Command inputs are
// single-cycle pulses that are consumed only when the FSM is in WAIT_CMD.
// Pulses arriving in any other state are dropped.
module semi_auto_ctrl #(
  parameter logic [31:0] TURN_CYCLES  = 32'd100000000,
  parameter logic [31:0] CLEAR_CYCLES = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       front_det,
  input  logic       left_det,
  input  logic       right_det,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       go_straight,
  input  logic       go_back,
  output logic       forward,
  output logic       rot_left,
  output logic       rot_right,
  output logic       waiting,
  output logic [2:0] cur_state
);

`ifdef SEMI_AUTO_DEADEND_EN
  localparam logic DEADEND_EN = 1'b1;
`else
  localparam logic DEADEND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_WAIT_CMD  = 3'd2,
    S_TURN_L    = 3'd3,
    S_TURN_R    = 3'd4,
    S_TURN_BACK = 3'd5,
    S_CLEAR     = 3'd6
  } state_t;

  // U-turn length is twice a 90 degree turn; kept in 33 bits so the
  // largest legal TURN_CYCLES cannot wrap.
  localparam logic [32:0] BACK_LIMIT = {1'b0, TURN_CYCLES} << 1;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        forward_q, forward_d;
  logic        rot_left_q, rot_left_d;
  logic        rot_right_q, rot_right_d;
  logic        waiting_q, waiting_d;

  logic dead_end;
  logic stop_cond;
  logic turn_done;
  logic back_done;
  logic clear_done;

  assign dead_end   = front_det & left_det & right_det;
  assign stop_cond  = front_det | ~left_det | ~right_det;
  assign turn_done  = (cnt_q == TURN_CYCLES - 32'd1);
  assign back_done  = ({1'b0, cnt_q} == BACK_LIMIT - 33'd1);
  assign clear_done = (cnt_q == CLEAR_CYCLES - 32'd1);

  // Next-state, counter and Moore output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = 32'd0;

    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (DEADEND_EN && dead_end) begin
          state_d = S_TURN_BACK;
        end else if (stop_cond) begin
          state_d = S_WAIT_CMD;
        end
      end
      S_WAIT_CMD: begin
        if (DEADEND_EN && dead_end) begin
          state_d = S_TURN_BACK;
        end else if (go_straight) begin
          // A blocked straight request is swallowed; lower-priority
          // commands in the same cycle are not considered.
          if (!front_det) begin
            state_d = S_CLEAR;
          end
        end else if (turn_left) begin
          state_d = S_TURN_L;
        end else if (turn_right) begin
          state_d = S_TURN_R;
        end else if (go_back) begin
          state_d = S_TURN_BACK;
        end
      end
      S_TURN_L, S_TURN_R: begin
        cnt_d = cnt_q + 32'd1;
        if (turn_done) begin
          state_d = S_CLEAR;
        end
      end
      S_TURN_BACK: begin
        cnt_d = cnt_q + 32'd1;
        if (back_done) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 32'd1;
        if (clear_done) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every state entry starts the counter from zero.
    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end

    // Dropping out of semi-auto mode overrides everything else.
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = 32'd0;
    end

    forward_d   = (state_d == S_RUN) || (state_d == S_CLEAR);
    rot_left_d  = (state_d == S_TURN_L);
    rot_right_d = (state_d == S_TURN_R) || (state_d == S_TURN_BACK);
    waiting_d   = (state_d == S_WAIT_CMD);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      forward_q   <= 1'b0;
      rot_left_q  <= 1'b0;
      rot_right_q <= 1'b0;
      waiting_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      forward_q   <= forward_d;
      rot_left_q  <= rot_left_d;
      rot_right_q <= rot_right_d;
      waiting_q   <= waiting_d;
    end
  end

  assign forward   = forward_q;
  assign rot_left  = rot_left_q;
  assign rot_right = rot_right_q;
  assign waiting   = waiting_q;
  assign cur_state = state_q;

endmodule

// File: tb/tb_semi_auto_ctrl.sv
// Bench for semi_auto_ctrl with TURN_CYCLES=4, CLEAR_CYCLES=3.
// A behavioural model (mode code plus a countdown of remaining cycles)
// predicts state and outputs after every clock edge.
module tb_semi_auto_ctrl;

  localparam int TURN  = 4;
  localparam int CLR   = 3;
`ifdef SEMI_AUTO_DEADEND_EN
  localparam bit MODEL_DEADEND = 1'b1;
`else
  localparam bit MODEL_DEADEND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       front_det = 1'b0;
  logic       left_det = 1'b1;
  logic       right_det = 1'b1;
  logic       turn_left = 1'b0;
  logic       turn_right = 1'b0;
  logic       go_straight = 1'b0;
  logic       go_back = 1'b0;
  logic       forward;
  logic       rot_left;
  logic       rot_right;
  logic       waiting;
  logic [2:0] cur_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode uses the published state codes; remain counts cycles left.
  int m_mode   = 0;
  int m_remain = 0;

  semi_auto_ctrl #(
    .TURN_CYCLES (32'd4),
    .CLEAR_CYCLES(32'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .front_det  (front_det),
    .left_det   (left_det),
    .right_det  (right_det),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .go_straight(go_straight),
    .go_back    (go_back),
    .forward    (forward),
    .rot_left   (rot_left),
    .rot_right  (rot_right),
    .waiting    (waiting),
    .cur_state  (cur_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void enter(input int mode);
    m_mode = mode;
    if (mode == 5)      m_remain = 2 * TURN;
    else if (mode == 6) m_remain = CLR;
    else if (mode == 3 || mode == 4) m_remain = TURN;
    else m_remain = 0;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  function automatic void model_step();
    bit dead;
    bit stop;
    dead = front_det && left_det && right_det;
    stop = front_det || !left_det || !right_det;
    if (rst || !enable) begin
      enter(0);
    end else begin
      case (m_mode)
        0: enter(1);
        1: begin
          if (MODEL_DEADEND && dead) enter(5);
          else if (stop) enter(2);
        end
        2: begin
          if (MODEL_DEADEND && dead) enter(5);
          else if (go_straight) begin
            if (!front_det) enter(6);
          end
          else if (turn_left)  enter(3);
          else if (turn_right) enter(4);
          else if (go_back)    enter(5);
        end
        3, 4, 5: begin
          m_remain--;
          if (m_remain == 0) enter(6);
        end
        default: begin
          m_remain--;
          if (m_remain == 0) enter(1);
        end
      endcase
    end
  endfunction

  // One clock: model update at the edge, compare 1 time unit later.
  task automatic cycle();
    logic [3:0] exp_out;
    @(posedge clk);
    model_step();
    #1;
    exp_out = {m_mode == 1 || m_mode == 6, m_mode == 3,
               m_mode == 4 || m_mode == 5, m_mode == 2};
    check("model_state", {29'd0, cur_state}, m_mode);
    check("model_outs", {28'd0, forward, rot_left, rot_right, waiting}, {28'd0, exp_out});
  endtask

  task automatic pulse_cmd(input logic tl, input logic tr, input logic gs, input logic gb);
    turn_left = tl; turn_right = tr; go_straight = gs; go_back = gb;
    cycle();
    turn_left = 1'b0; turn_right = 1'b0; go_straight = 1'b0; go_back = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset with enable high.
    rst = 1'b1; enable = 1'b1;
    run_cycles(2);
    check("reset_state", {29'd0, cur_state}, 0);
    check("reset_outs", {28'd0, forward, rot_left, rot_right, waiting}, 0);
    rst = 1'b0;
    cycle();
    check("release_run", {29'd0, cur_state}, 1);
    check("release_fwd", {31'd0, forward}, 1);

    // Intersection stop.
    run_cycles(2);
    left_det = 1'b0;
    cycle();
    check("stop_wait", {29'd0, cur_state}, 2);
    check("stop_waiting", {31'd0, waiting}, 1);

    // Left turn, clearance, then back to WAIT since left is still open.
    pulse_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("left_rot", {31'd0, rot_left}, 1);
    run_cycles(3);
    check("left_last_rot", {31'd0, rot_left}, 1);
    cycle();
    check("left_to_clear", {29'd0, cur_state}, 6);
    run_cycles(2);
    check("clear_last", {31'd0, forward}, 1);
    cycle();
    check("clear_to_run", {29'd0, cur_state}, 1);
    cycle();
    check("rerun_wait", {29'd0, cur_state}, 2);

    // Blocked straight and priority.
    front_det = 1'b1;
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("blocked_straight", {29'd0, cur_state}, 2);
    pulse_cmd(1'b0, 1'b0, 1'b1, 1'b1);
    check("straight_over_back", {29'd0, cur_state}, 2);
    pulse_cmd(1'b0, 1'b1, 1'b0, 1'b1);
    check("right_over_back", {29'd0, cur_state}, 4);
    front_det = 1'b0;
    run_cycles(4 + 3 + 1);
    check("after_right_wait", {29'd0, cur_state}, 2);

    // U-turn: 8 cycles of rot_right then CLEAR.
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
    run_cycles(7);
    check("uturn_last_rot", {31'd0, rot_right}, 1);
    cycle();
    check("uturn_to_clear", {29'd0, cur_state}, 6);
    run_cycles(3 + 1);

    // U-turn aborted by enable=0 on its fifth cycle.
    pulse_cmd(1'b0, 1'b0, 1'b0, 1'b1);
    run_cycles(4);
    enable = 1'b0;
    cycle();
    check("abort_idle", {29'd0, cur_state}, 0);
    check("abort_outs", {28'd0, forward, rot_left, rot_right, waiting}, 0);

    // Dead end seen while entering RUN.
    front_det = 1'b1; left_det = 1'b1; right_det = 1'b1;
    enable = 1'b1;
    cycle();
    check("deadend_run", {29'd0, cur_state}, 1);
    cycle();
    check("deadend_next", {29'd0, cur_state}, MODEL_DEADEND ? 5 : 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      enable      = ($urandom_range(0, 99) > 2);
      front_det   = ($urandom_range(0, 9) < 3);
      left_det    = ($urandom_range(0, 9) < 8);
      right_det   = ($urandom_range(0, 9) < 8);
      turn_left   = ($urandom_range(0, 9) == 0);
      turn_right  = ($urandom_range(0, 9) == 0);
      go_straight = ($urandom_range(0, 9) == 0);
      go_back     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
